uart_fifo_tx: RTL and testbench

- Read-side consumer of uart_fifo. Drains bytes from the FIFO read port and serializes each one onto a UART line as an 8N1 frame: start bit, 8 data bits LSB-first, 1 stop bit.
- Sits between uart_fifo (rdclk domain) and the board TX pin. This is the transmit counterpart to the FIFO's writer.

---
 rtl/uart_fifo_tx.sv | 181 ++++++++++++++++++
 tb/tb_uart_fifo_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// ----------------------------------------------------------------------------
// uart_fifo_tx
//
// Drains bytes from the read port of a normal-mode FIFO and sends each one on
// a UART line as an 8N1 frame: one start bit, eight data bits LSB first, and
// one stop bit. The FIFO read clock is the same clk, so there is only one
// clock domain.
//
// Ports:
//   clk         system clock (also the FIFO rdclk)
//   rst         synchronous, active-high reset
//   enable      allows a new byte to be fetched; looked at only while idle
//   rdempty     FIFO empty flag; looked at only while idle
//   q[7:0]      FIFO read data, valid the cycle after rdreq was sampled
//   rdreq       FIFO read request, registered one-cycle pulse
//   tx          serial line, idles high
//   busy        high whenever the engine is not idle
//   frame_done  one-cycle pulse at the end of each stop bit
//
// Fetch sequence: IDLE -> REQ (rdreq high) -> LATCH (q valid).
// The frame then runs START -> DATA x8 -> STOP, each bit CLKS_PER_BIT cycles.
// ----------------------------------------------------------------------------
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rdempty,
    input  logic [7:0] q,
    output logic       rdreq,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    // Counter width is at least one bit, even for the smallest legal CLKS_PER_BIT.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            rdreq_q, rdreq_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // High on the last clock of the current bit period.
    logic bit_end;
    assign bit_end = (cnt_q == CNT_MAX);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: registers are written with non-blocking assignments so every
    // register samples the values from before the edge, whatever order the
    // statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rdreq_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rdreq_q <= rdreq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case statement. Without it,
    // any path that leaves state_d unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable && !rdempty) state_d = S_REQ;
            S_REQ:   state_d = S_LATCH;
            S_LATCH: state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:  if (bit_end && (idx_q == 3'd7)) state_d = S_STOP;
            S_STOP:  if (bit_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath next-values
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        rdreq_d = 1'b0;
        done_d  = 1'b0;
        // busy follows the state the engine is moving into, so the
        // registered flag lines up with state_q.
        busy_d  = (state_d != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (state_d == S_REQ) rdreq_d = 1'b1;
            end
            S_REQ: begin
                // rdreq drops here; the FIFO has already taken the request.
            end
            S_LATCH: begin
                shift_d = q;
                tx_d    = 1'b0;
                cnt_d   = '0;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = '0;
                    tx_d  = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        // The next bit is shift_q[1], which becomes shift_d[0].
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                tx_d  = 1'b1;
                cnt_d = '0;
            end
        endcase
    end

    assign rdreq      = rdreq_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_fifo_tx
//
// Bench for uart_fifo_tx with CLKS_PER_BIT = 4. A small array-based model
// stands in for a normal-mode FIFO. Directed frames are compared cycle by
// cycle against hand-written 10-bit line patterns, with bit i being the i-th
// bit on the wire. Random bytes are then checked by a UART receiver model
// that recovers each byte and measures the gap between frames.
// ----------------------------------------------------------------------------
module tb_uart_fifo_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rdempty;
    logic [7:0] q;
    logic       rdreq;
    logic       tx;
    logic       busy;
    logic       frame_done;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rdempty    (rdempty),
        .q          (q),
        .rdreq      (rdreq),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model (normal mode: q valid after rdreq) -------
    logic [7:0] mem [0:255];
    int wr_ptr = 0;          // written only by the stimulus process
    int rd_ptr = 0;          // written only by the FIFO process
    int underflow_cnt = 0;

    assign rdempty = (wr_ptr == rd_ptr);

    initial q = 8'h00;

    always @(posedge clk) begin
        if (rdreq) begin
            if (wr_ptr == rd_ptr) begin
                underflow_cnt = underflow_cnt + 1;
            end else begin
                q <= mem[rd_ptr[7:0]];
                rd_ptr = rd_ptr + 1;
            end
        end
    end

    // ---------------- event monitor ----------------
    int  rdreq_cnt = 0;
    int  rdreq_long_cnt = 0;
    int  done_cnt = 0;
    logic prev_rdreq = 1'b0;

    always @(negedge clk) begin
        if (rdreq === 1'b1) rdreq_cnt = rdreq_cnt + 1;
        if (rdreq === 1'b1 && prev_rdreq === 1'b1) rdreq_long_cnt = rdreq_long_cnt + 1;
        if (frame_done === 1'b1) done_cnt = done_cnt + 1;
        prev_rdreq = rdreq;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits for the fetch, then checks every cycle of the frame against the
    // pattern `wave`. Setting drop_at or rst_at to a sample index (0..39)
    // drops enable, or pulses rst, right after that sample.
    task automatic wave_check(input logic [9:0] wave, input int exp_wait,
                              input int drop_at, input int rst_at);
        int w;
        w = 0;
        while (rdreq !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (rdreq !== 1'b1) begin
            check("rdreq_timeout", 32'(rdreq), 32'd1);
            return;
        end
        check("fetch_latency", 32'(w), 32'(exp_wait));
        check("frame_done_width", 32'(frame_done), 32'd0);
        @(negedge clk);
        check("rdreq_one_cycle", 32'(rdreq), 32'd0);
        check("tx_before_start", 32'(tx), 32'd1);
        check("busy_in_fetch", 32'(busy), 32'd1);
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            check("tx_bit", 32'(tx), 32'(wave[k / CPB]));
            check("busy_in_frame", 32'(busy), 32'd1);
            if (k == drop_at) enable = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_abort_tx", 32'(tx), 32'd1);
                check("rst_abort_busy", 32'(busy), 32'd0);
                check("rst_abort_rdreq", 32'(rdreq), 32'd0);
                return;
            end
        end
        @(negedge clk);
        check("frame_done", 32'(frame_done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("tx_after", 32'(tx), 32'd1);
    endtask

    // UART receiver model: samples the middle of each bit, recovers the byte,
    // and measures the idle-high gap between consecutive frames.
    logic [7:0] expq[$];

    task automatic decode_frames(input int n);
        int waited;
        logic [7:0] d;
        for (int f = 0; f < n; f++) begin
            waited = 0;
            while (tx === 1'b1 && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (tx !== 1'b0) begin
                check("rx_start_timeout", 32'(tx), 32'd0);
                return;
            end
            if (f > 0) check("rx_gap", 32'(waited), 32'd3);
            repeat (CPB / 2) @(negedge clk);
            check("rx_start_mid", 32'(tx), 32'd0);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(negedge clk);
                d[b] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("rx_stop", 32'(tx), 32'd1);
            check("rx_byte", 32'(d), 32'(expq.pop_front()));
            repeat (CPB - CPB / 2) @(negedge clk);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] wave;     // line pattern, bit 0 = start bit
        int         push;     // bytes pushed from this entry onward before it runs
        int         exp_wait;
        int         drop_at;
        int         rst_at;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h55, 10'b1010101010, 1, 1, -1, -1};
        tbl[1] = '{8'h01, 10'b1000000010, 3, 1, -1, -1};
        tbl[2] = '{8'h80, 10'b1100000000, 0, 1, -1, -1};
        tbl[3] = '{8'hFF, 10'b1111111110, 0, 1, -1, -1};

        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rdreq", 32'(rdreq), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // Empty FIFO with enable high: the engine must stay idle.
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("empty_idle_tx", 32'(tx), 32'd1);
            check("empty_idle_rdreq", 32'(rdreq), 32'd0);
            check("empty_idle_busy", 32'(busy), 32'd0);
        end

        // Single frame, then three back-to-back frames.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < tbl[i].push; j++) push_byte(tbl[i + j].data);
            wave_check(tbl[i].wave, tbl[i].exp_wait, tbl[i].drop_at, tbl[i].rst_at);
        end
        check("b2b_fifo_empty", 32'(wr_ptr - rd_ptr), 32'd0);
        check("b2b_rdreq_count", 32'(rdreq_cnt), 32'd4);

        // enable low with data waiting: nothing is fetched.
        enable = 1'b0;
        push_byte(8'hC3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("disabled_rdreq", 32'(rdreq), 32'd0);
            check("disabled_tx", 32'(tx), 32'd1);
        end
        enable = 1'b1;
        wave_check(10'b1110000110, 1, -1, -1);

        // Drop enable during data bit 3: the frame finishes, with no refetch.
        push_byte(8'hA5);
        push_byte(8'h11);
        wave_check(10'b1101001010, 1, 17, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("dropped_en_rdreq", 32'(rdreq), 32'd0);
        end
        check("dropped_en_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
        enable = 1'b1;
        wave_check(10'b1000100010, 1, -1, -1);

        // Reset during data bit 5 of 0x3C; the next byte still goes out intact.
        push_byte(8'h3C);
        push_byte(8'h96);
        wave_check(10'b1001111000, 1, -1, 25);
        wave_check(10'b1100101100, 1, -1, -1);

        // Random bytes in two bursts, checked by the receiver model.
        for (int burst = 0; burst < 2; burst++) begin
            int nb;
            logic [7:0] b;
            nb = $urandom_range(2, 6);
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                push_byte(b);
                expq.push_back(b);
            end
            decode_frames(nb);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("final_fifo_empty", 32'(wr_ptr - rd_ptr), 32'd0);
        check("final_rdreq_count", 32'(rdreq_cnt), 32'(wr_ptr));
        check("final_frame_done_count", 32'(done_cnt), 32'(wr_ptr - 1));
        check("rdreq_longer_than_1", 32'(rdreq_long_cnt), 32'd0);
        check("fifo_underflow", 32'(underflow_cnt), 32'd0);
        check("final_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
